// File: rtl/reset_sequencer_pkg.sv
// Shared processor-control definitions for the software reset sequencer:
// state encoding, reset-vector bit positions and the step-ordering helper.
package reset_sequencer_pkg;

  localparam int RST_FULL = 3;
  localparam int RST_INST = 2;
  localparam int RST_IO   = 1;
  localparam int RST_DATA = 0;

  typedef logic [3:0] resetVector_t;
  typedef logic [1:0] timeoutStatus_t;

  typedef enum logic [2:0] {
    IDLE,
    FULL,
    IO_WAIT,
    DATA_WAIT,
    INST,
    RESPOND
  } seqState_t;

  function automatic int maxOf3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // First pending step after 'cur' in the order FULL, IO_WAIT, DATA_WAIT, INST,
  // RESPOND. Later steps are tested first so the earliest pending one wins.
  function automatic seqState_t nextStep(resetVector_t vec, seqState_t cur);
    seqState_t nxt;
    nxt = RESPOND;
    if (vec[RST_INST] && cur != INST && cur != RESPOND) nxt = INST;
    if (vec[RST_DATA] && (cur == IDLE || cur == FULL || cur == IO_WAIT)) nxt = DATA_WAIT;
    if (vec[RST_IO] && (cur == IDLE || cur == FULL)) nxt = IO_WAIT;
    if (vec[RST_FULL] && cur == IDLE) nxt = FULL;
    return nxt;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/acknowledge bundle between the reset sequencer (master) and the
// processor control plus reset domains it serves (slave).
interface reset_sequencer_if;
  import reset_sequencer_pkg::*;

  logic           SoftwareResetIn;
  resetVector_t   ResetVectorIn;
  logic           IOResetReqOut;
  logic           IOResetAckIn;
  logic           DataResetReqOut;
  logic           DataResetAckIn;
  logic           InstResetOut;
  logic           FullResetOut;
  logic           ResetResponseOut;
  timeoutStatus_t TimeoutStatusOut;
  logic           Busy;

  modport master (
    input  SoftwareResetIn, ResetVectorIn, IOResetAckIn, DataResetAckIn,
    output IOResetReqOut, DataResetReqOut, InstResetOut, FullResetOut,
           ResetResponseOut, TimeoutStatusOut, Busy
  );

  modport slave (
    output SoftwareResetIn, ResetVectorIn, IOResetAckIn, DataResetAckIn,
    input  IOResetReqOut, DataResetReqOut, InstResetOut, FullResetOut,
           ResetResponseOut, TimeoutStatusOut, Busy
  );
endinterface

// File: rtl/reset_seq_counter.sv
// Loadable, clock-enable gated down-counter that saturates at zero; shared by
// all timed steps of the reset sequencer.
module reset_seq_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             sync_rst,
  input  logic             clk_en,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  output logic             isZero
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      count <= '0;
    end else if (clk_en) begin
      if (load) begin
        count <= loadValue;
      end else if (count != '0) begin
        count <= count - WIDTH'(1);
      end
    end
  end

  assign isZero = (count == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Software reset sequencer: walks FULL, IO, DATA and INST reset steps selected
// by the latched vector, then returns a one-cycle completion pulse.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int FULL_RESET_CYCLES = 16,
  parameter int INST_RESET_CYCLES = 4,
  parameter int ACK_TIMEOUT       = 255
) (
  input  logic               clk,
  input  logic               sync_rst,
  input  logic               clk_en,
  reset_sequencer_if.master  seqBus
);

  localparam int CountWidth = $clog2(maxOf3(FULL_RESET_CYCLES, INST_RESET_CYCLES, ACK_TIMEOUT) + 1);

  seqState_t        state, nextState;
  resetVector_t     workVec, nextVec, acceptedVec;
  timeoutStatus_t   timeoutStatus, nextStatus;
  logic             cntLoad, cntZero;
  logic [CountWidth-1:0] cntLoadValue;

  reset_seq_counter #(.WIDTH(CountWidth)) u_counter (
    .clk       (clk),
    .sync_rst  (sync_rst),
    .clk_en    (clk_en),
    .load      (cntLoad),
    .loadValue (cntLoadValue),
    .isZero    (cntZero)
  );

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state         <= IDLE;
      workVec       <= '0;
      timeoutStatus <= '0;
    end else begin
      state         <= nextState;
      workVec       <= nextVec;
      timeoutStatus <= nextStatus;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    nextState    = state;
    nextVec      = workVec;
    nextStatus   = timeoutStatus;
    cntLoad      = 1'b0;
    cntLoadValue = '0;

    acceptedVec = seqBus.ResetVectorIn;
    if (acceptedVec[RST_FULL]) begin
      acceptedVec[RST_INST] = 1'b1;
      acceptedVec[RST_IO]   = 1'b1;
      acceptedVec[RST_DATA] = 1'b1;
    end

    if (clk_en) begin
      case (state)
        IDLE: begin
          if (seqBus.SoftwareResetIn) begin
            nextVec    = acceptedVec;
            nextStatus = '0;
            nextState  = nextStep(acceptedVec, IDLE);
          end
        end
        FULL, INST: begin
          if (cntZero) nextState = nextStep(workVec, state);
        end
        // Acknowledge is tested before expiry so a same-edge ack sets no flag.
        IO_WAIT: begin
          if (seqBus.IOResetAckIn) begin
            nextState = nextStep(workVec, state);
          end else if (cntZero) begin
            nextStatus[1] = 1'b1;
            nextState     = nextStep(workVec, state);
          end
        end
        DATA_WAIT: begin
          if (seqBus.DataResetAckIn) begin
            nextState = nextStep(workVec, state);
          end else if (cntZero) begin
            nextStatus[0] = 1'b1;
            nextState     = nextStep(workVec, state);
          end
        end
        RESPOND: nextState = IDLE;
        default: nextState = IDLE;
      endcase

      // Counter holds remaining cycles minus one, so the step ends on the
      // edge where it already reads zero.
      if (nextState != state) begin
        cntLoad = 1'b1;
        case (nextState)
          FULL:               cntLoadValue = CountWidth'(FULL_RESET_CYCLES - 1);
          INST:               cntLoadValue = CountWidth'(INST_RESET_CYCLES - 1);
          IO_WAIT, DATA_WAIT: cntLoadValue = CountWidth'(ACK_TIMEOUT - 1);
          default:            cntLoadValue = '0;
        endcase
      end
    end
  end

  assign seqBus.FullResetOut     = (state == FULL);
  assign seqBus.IOResetReqOut    = (state == IO_WAIT);
  assign seqBus.DataResetReqOut  = (state == DATA_WAIT);
  assign seqBus.InstResetOut     = (state == INST);
  assign seqBus.ResetResponseOut = (state == RESPOND);
  assign seqBus.Busy             = (state != IDLE);
  assign seqBus.TimeoutStatusOut = timeoutStatus;

endmodule
